// File: rtl/brc_seq_pkg.sv
// Shared types and the funct3 branch-decision helper for the sequential branch comparator.
package brc_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_e;

  // Illegal funct3 encodings (010/011) never take the branch.
  function automatic logic taken_f(input logic [2:0] br_op, input logic less, input logic equal);
    logic t;
    case (br_op)
      BR_BEQ:           t = equal;
      BR_BNE:           t = !equal;
      BR_BLT, BR_BLTU:  t = less;
      BR_BGE, BR_BGEU:  t = !less;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/brc_seq_if.sv
// Request/result handshake bundle between register-read and PC-select stages.
interface brc_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            br_un;
  logic [2:0]      br_op;
  logic            out_valid;
  logic            out_ready;
  logic            br_less;
  logic            br_equal;
  logic            br_taken;

  modport master (
    output in_valid, rs1_data, rs2_data, br_un, br_op, out_ready,
    input  in_ready, out_valid, br_less, br_equal, br_taken
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data, br_un, br_op, out_ready,
    output in_ready, out_valid, br_less, br_equal, br_taken
  );
endinterface

// File: rtl/brc_seq_slice_cmp.sv
// Combinational CHUNK-bit magnitude/equality compare; msb_flip biases the sign bit
// so a signed top slice can be compared as unsigned.
module brc_slice_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_flip,
  output logic             lt,
  output logic             eq
);
  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_f;
  logic [CHUNK-1:0] b_f;

  always_comb begin
    flip            = '0;
    flip[CHUNK-1]   = msb_flip;
    a_f             = a ^ flip;
    b_f             = b ^ flip;
    lt              = (a_f < b_f);
    eq              = (a_f == b_f);
  end
endmodule

// File: rtl/brc_seq.sv
// Multi-cycle branch comparator: walks operands MSB slice first, latching the first
// differing slice's ordering, then presents less/equal/taken until consumed.
module brc_seq
  import brc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 0
) (
  input logic       clk,
  input logic       rst,
  brc_seq_if.slave  bus
);
  localparam int NSLICE = XLEN / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

  state_e          state, state_nx;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      op_q;
  logic            uns_q;
  logic [IDXW-1:0] idx;
  logic            less_q, eq_q, decided_q;

  logic [XLEN-1:0] a_sh, b_sh;
  logic            msb_flip, slice_lt, slice_eq, first_diff;

  always_comb begin
    a_sh       = a_q >> (CHUNK * int'(idx));
    b_sh       = b_q >> (CHUNK * int'(idx));
    msb_flip   = !uns_q && (idx == TOP_IDX);
    first_diff = (state == CMP) && !decided_q && !slice_eq;
  end

  brc_slice_cmp #(.CHUNK(CHUNK)) u_cmp (
    .a        (a_sh[CHUNK-1:0]),
    .b        (b_sh[CHUNK-1:0]),
    .msb_flip (msb_flip),
    .lt       (slice_lt),
    .eq       (slice_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = CMP;
      CMP:  if (((EARLY_EXIT != 0) && first_diff) || (idx == '0)) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result starts as "equal"; only the first differing slice may overwrite it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      uns_q     <= 1'b0;
      idx       <= '0;
      less_q    <= 1'b0;
      eq_q      <= 1'b0;
      decided_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q       <= bus.rs1_data;
          b_q       <= bus.rs2_data;
          op_q      <= bus.br_op;
          uns_q     <= bus.br_un | bus.br_op[1];
          idx       <= TOP_IDX;
          less_q    <= 1'b0;
          eq_q      <= 1'b1;
          decided_q <= 1'b0;
        end
        CMP: begin
          if (first_diff) begin
            less_q    <= slice_lt;
            eq_q      <= 1'b0;
            decided_q <= 1'b1;
          end
          idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Results are gated by DONE so nothing stale is visible outside a valid beat.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.br_less   = (state == DONE) && less_q;
  assign bus.br_equal  = (state == DONE) && eq_q;
  assign bus.br_taken  = (state == DONE) && taken_f(op_q, less_q, eq_q);
endmodule

// File: tb/tb_brc_seq.sv
// Directed bench for brc_seq: three configurations (8-bit slices fixed latency,
// 8-bit slices early exit, single 32-bit slice) sharing one clock and reset.
module tb_brc_seq;
  import brc_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  brc_seq_if #(.XLEN(32)) if0 ();
  brc_seq_if #(.XLEN(32)) if1 ();
  brc_seq_if #(.XLEN(32)) if2 ();

  brc_seq #(.XLEN(32), .CHUNK(8),  .EARLY_EXIT(0)) u_fix (.clk(clk), .rst(rst), .bus(if0));
  brc_seq #(.XLEN(32), .CHUNK(8),  .EARLY_EXIT(1)) u_ee  (.clk(clk), .rst(rst), .bus(if1));
  brc_seq #(.XLEN(32), .CHUNK(32), .EARLY_EXIT(0)) u_one (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic un, input logic [2:0] op);
    case (sel)
      0: begin if0.in_valid = v; if0.rs1_data = a; if0.rs2_data = b; if0.br_un = un; if0.br_op = op; end
      1: begin if1.in_valid = v; if1.rs1_data = a; if1.rs2_data = b; if1.br_un = un; if1.br_op = op; end
      default: begin if2.in_valid = v; if2.rs1_data = a; if2.rs2_data = b; if2.br_un = un; if2.br_op = op; end
    endcase
  endtask

  // {in_ready, out_valid, br_less, br_equal, br_taken}
  function automatic logic [4:0] obs(input int sel);
    case (sel)
      0:       return {if0.in_ready, if0.out_valid, if0.br_less, if0.br_equal, if0.br_taken};
      1:       return {if1.in_ready, if1.out_valid, if1.br_less, if1.br_equal, if1.br_taken};
      default: return {if2.in_ready, if2.out_valid, if2.br_less, if2.br_equal, if2.br_taken};
    endcase
  endfunction

  // Issue one request at edge E0 and return the number of edges until out_valid (99 = timeout).
  task automatic run(input int sel, input logic [31:0] a, input logic [31:0] b, input logic un,
                     input logic [2:0] op, output int lat);
    logic [4:0] s;
    drive(sel, 1'b1, a, b, un, op);
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    lat = 0;
    s   = obs(sel);
    while (!s[3] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      s = obs(sel);
    end
    if (!s[3]) lat = 99;
  endtask

  initial begin
    int         lat;
    logic [4:0] s;
    logic       seen;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    drive(2, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s = obs(0);
    check("rst_outs_fix", 32'(s), 32'b10000);
    s = obs(2);
    check("rst_outs_one", 32'(s), 32'b10000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Equal operands, BEQ, fixed latency of 4 slices
    run(0, 32'h10, 32'h10, 1'b0, BR_BEQ, lat);
    check("beq_lat", 32'(lat), 32'd4);
    s = obs(0);
    check("beq_res", 32'(s[2:0]), 32'b011);
    @(posedge clk); #1;
    check("beq_idle", 32'(obs(0)), 32'b10000);

    // Signed vs unsigned ordering of 6 vs -11
    run(0, 32'h6, 32'hFFFF_FFF5, 1'b0, BR_BLT, lat);
    s = obs(0);
    check("blt_res", 32'(s[2:0]), 32'b000);
    @(posedge clk); #1;
    run(0, 32'h6, 32'hFFFF_FFF5, 1'b0, BR_BLTU, lat);
    s = obs(0);
    check("bltu_res", 32'(s[2:0]), 32'b101);
    check("bltu_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // Early exit: difference found in third slice examined
    run(1, 32'hFFFF_FE50, 32'hFFFF_FF56, 1'b0, BR_BGE, lat);
    check("ee_bge_lat", 32'(lat), 32'd3);
    s = obs(1);
    check("ee_bge_res", 32'(s[2:0]), 32'b100);
    @(posedge clk); #1;
    run(1, 32'h6, 32'hFFFF_FFF5, 1'b0, BR_BLT, lat);
    check("ee_blt_lat", 32'(lat), 32'd1);
    s = obs(1);
    check("ee_blt_res", 32'(s[2:0]), 32'b000);
    @(posedge clk); #1;

    // Backpressure: hold result for 5 cycles while a competing request is offered
    if0.out_ready = 1'b0;
    run(0, 32'h6, 32'hFFFF_FFF5, 1'b0, BR_BNE, lat);
    check("bp_lat", 32'(lat), 32'd4);
    drive(0, 1'b1, 32'h5, 32'h9, 1'b1, BR_BEQ);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", i), 32'(obs(0)), 32'b01001);
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'(obs(0)), 32'b10000);
    run(0, 32'h5, 32'h5, 1'b0, BR_BGEU, lat);
    check("bp_next_lat", 32'(lat), 32'd4);
    s = obs(0);
    check("bp_next_res", 32'(s[2:0]), 32'b011);
    @(posedge clk); #1;

    // Reset during CMP aborts the request
    drive(0, 1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFFF, 1'b0, BR_BLT);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort", 32'(obs(0)), 32'b10000);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      s = obs(0);
      if (s[3]) seen = 1'b1;
    end
    check("rst_no_stale", 32'(seen), 32'd0);

    // Single-slice configuration with an illegal funct3
    run(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b010, lat);
    check("one_lat", 32'(lat), 32'd1);
    s = obs(2);
    check("one_res", 32'(s[2:0]), 32'b010);
    @(posedge clk); #1;
    check("one_idle", 32'(obs(2)), 32'b10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
